// File: rtl/dvi_scanout.sv
// dvi_scanout: pixel FIFO fed by frame_buffer, 640x480-style raster timing,
// and a single tick-aligned output register stage driving the DVI transmitter.
// Handshake: the writer may push on any cycle where dvi_fifo_full was low on the
// previous clock; one extra push after full rises is still absorbed, and a push
// into a truly full FIFO is dropped and flagged in overflow.
module dvi_scanout #(
   parameter int DEPTH    = 64,
   parameter int PREFILL  = 32,
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fb_write_enable,
   input  logic [2:0] fb_color_in,
   output logic       dvi_fifo_full,
   output logic       dvi_hsync,
   output logic       dvi_vsync,
   output logic       dvi_de,
   output logic [7:0] dvi_r,
   output logic [7:0] dvi_g,
   output logic [7:0] dvi_b,
   output logic       underflow,
   output logic       overflow
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int AW      = $clog2(DEPTH);
   localparam int DIVW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
   localparam logic [HW-1:0]   H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0]   V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [AW:0]     DEPTH_L  = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_ACTIVE = 2'd2
   } state_e;

   state_e          state_q;
   logic [DIVW-1:0] div_q;
   logic [HW-1:0]   h_q;
   logic [VW-1:0]   v_q;
   logic [AW:0]     wr_ptr_q;
   logic [AW:0]     rd_ptr_q;
   logic [2:0]      mem_q [DEPTH];
   logic            full_q;
   logic            hs_q;
   logic            vs_q;
   logic            de_q;
   logic [2:0]      rgb_q;
   logic            unf_q;
   logic            ovf_q;

   logic            tick;
   logic            active;
   logic            hs_low;
   logic            vs_low;
   logic            frame_start;
   logic            live;
   logic            slot;
   logic [AW:0]     count;
   logic [AW:0]     count_d;
   logic            fifo_empty;
   logic            fifo_true_full;
   logic            push;
   logic            pop;
   logic [2:0]      head;

   assign tick        = (div_q == '0);
   assign active      = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
   assign hs_low      = (int'(h_q) >= H_ACTIVE + H_FP) && (int'(h_q) < H_ACTIVE + H_FP + H_SYNC);
   assign vs_low      = (int'(v_q) >= V_ACTIVE + V_FP) && (int'(v_q) < V_ACTIVE + V_FP + V_SYNC);
   assign frame_start = tick && (h_q == '0) && (v_q == '0);

   // ARMED counts as live on the frame-start tick so pixel (0,0) is the first pop.
   assign live = (state_q == ST_ACTIVE) || ((state_q == ST_ARMED) && frame_start);
   assign slot = tick && active && live;

   assign count          = wr_ptr_q - rd_ptr_q;
   assign fifo_empty     = (count == '0);
   assign fifo_true_full = (count == DEPTH_L);
   assign push           = fb_write_enable && !fifo_true_full;
   assign pop            = slot && !fifo_empty;
   assign head           = mem_q[rd_ptr_q[AW-1:0]];

   // Occupancy after this cycle's push/pop, used for the registered almost-full.
   always_comb begin
      count_d = count;
      if (push && !pop) begin
         count_d = count + 1'b1;
      end else if (pop && !push) begin
         count_d = count - 1'b1;
      end
   end

   // Pixel-tick divider.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
      end else if (div_q == DIV_LAST) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + 1'b1;
      end
   end

   // Horizontal and vertical raster counters, advanced on ticks.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_q <= '0;
         v_q <= '0;
      end else if (tick) begin
         if (h_q == H_LAST) begin
            h_q <= '0;
            v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
         end else begin
            h_q <= h_q + 1'b1;
         end
      end
   end

   // FIFO pointers; reset discards contents by equalising them.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // FIFO storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= fb_color_in;
      end
   end

   // Almost-full flag, one entry early to cover the push in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= 1'b0;
      end else begin
         full_q <= (int'(count_d) >= DEPTH - 1);
      end
   end

   // Scanout state: wait for prefill, then align to the next frame start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   if (int'(count) >= PREFILL) state_q <= ST_ARMED;
            ST_ARMED:  if (frame_start) state_q <= ST_ACTIVE;
            ST_ACTIVE: state_q <= ST_ACTIVE;
            default:   state_q <= ST_IDLE;
         endcase
      end
   end

   // Output register stage, one tick behind the counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
         de_q  <= 1'b0;
         rgb_q <= 3'b000;
      end else if (tick) begin
         hs_q  <= !hs_low;
         vs_q  <= !vs_low;
         de_q  <= active;
         rgb_q <= pop ? head : 3'b000;
      end
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         unf_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         if (slot && fifo_empty)                 unf_q <= 1'b1;
         if (fb_write_enable && fifo_true_full)  ovf_q <= 1'b1;
      end
   end

   assign dvi_fifo_full = full_q;
   assign dvi_hsync     = hs_q;
   assign dvi_vsync     = vs_q;
   assign dvi_de        = de_q;
   assign dvi_r         = {8{rgb_q[2]}};
   assign dvi_g         = {8{rgb_q[1]}};
   assign dvi_b         = {8{rgb_q[0]}};
   assign underflow     = unf_q;
   assign overflow      = ovf_q;

endmodule
